// File: rtl/seq_alu_pkg.sv
// Shared opcode encodings, muldiv mode select and handshake FSM states for seq_alu.
// No logic lives here; latency and backpressure are owned by the modules that import it.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL1 = 4'h4;
    localparam logic [3:0] OP_SHR1 = 4'h5;
    localparam logic [3:0] OP_ROL1 = 4'h6;
    localparam logic [3:0] OP_ROR1 = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_NAND = 4'hC;
    localparam logic [3:0] OP_XNOR = 4'hD;
    localparam logic [3:0] OP_GT   = 4'hE;
    localparam logic [3:0] OP_EQ   = 4'hF;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative shift-add multiplier / restoring divider sharing one hi:lo shift pair.
// Latency: WIDTH cycles after start, done high during the last; no backpressure, caller holds results.
module seq_alu_muldiv
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] prod_lo,
    output logic             hi_nonzero,
    output logic [WIDTH-1:0] quotient
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt;
    logic             busy;
    logic             mode_q;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opb;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] next_hi;
    logic [WIDTH-1:0] next_lo;

    // MUL: hi accumulates, lo shifts the multiplier out. DIV: hi is the remainder, lo shifts dividend out / quotient in.
    always_comb begin
        add_sum = {1'b0, hi} + (lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        trial   = {hi, lo[WIDTH-1]} - {1'b0, opb};
        next_hi = hi;
        next_lo = lo;
        if (mode_q == MODE_MUL) begin
            next_hi = add_sum[WIDTH:1];
            next_lo = {add_sum[0], lo[WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
            next_hi = trial[WIDTH-1:0];
            next_lo = {lo[WIDTH-2:0], 1'b1};
        end else begin
            next_hi = {hi[WIDTH-2:0], lo[WIDTH-1]};
            next_lo = {lo[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            busy   <= 1'b0;
            mode_q <= MODE_MUL;
            hi     <= '0;
            lo     <= '0;
            opb    <= '0;
        end else if (start) begin
            cnt    <= CW'(WIDTH - 1);
            busy   <= 1'b1;
            mode_q <= mode;
            hi     <= '0;
            lo     <= a;
            opb    <= b;
        end else if (busy) begin
            hi <= next_hi;
            lo <= next_lo;
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    assign done       = busy && (cnt == '0);
    assign prod_lo    = lo;
    assign hi_nonzero = |hi;
    assign quotient   = lo;

endmodule

// File: rtl/seq_alu.sv
// Handshaked WIDTH-bit ALU, 16 opcodes, registered result and flags.
// Latency: 1 cycle after accept (WIDTH+1 for MUL/DIV); holds result in DONE while out_ready is low.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             div_by_zero
);

    logic rst_meta;
    logic rst_sync_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta   <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_sync_n <= rst_meta;
        end
    end

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       op_q;
    logic             accept;

    logic             md_start;
    logic             md_mode;
    logic             md_done;
    logic [WIDTH-1:0] md_prod;
    logic             md_hi_nz;
    logic [WIDTH-1:0] md_quot;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign md_mode  = (op == OP_DIV) ? MODE_DIV : MODE_MUL;
    assign md_start = accept && ((op == OP_MUL) || ((op == OP_DIV) && (b != '0)));

    seq_alu_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk        (clk),
        .rst_n      (rst_sync_n),
        .start      (md_start),
        .mode       (md_mode),
        .a          (a),
        .b          (b),
        .done       (md_done),
        .prod_lo    (md_prod),
        .hi_nonzero (md_hi_nz),
        .quotient   (md_quot)
    );

    // State release waits for the synchronised reset; bundles offered in that two-cycle window are not taken.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (op == OP_MUL) begin
                        next_state = MUL;
                    end else if ((op == OP_DIV) && (b != '0)) begin
                        next_state = DIV;
                    end else begin
                        next_state = DONE;
                    end
                end
            end
            MUL, DIV: begin
                if (md_done) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= OP_ADD;
        end else if (accept) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
        end
    end

    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_dbz;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_dbz   = 1'b0;
        sum       = {1'b0, a_q} + {1'b0, b_q};
        diff      = {1'b0, a_q} - {1'b0, b_q};
        case (op_q)
            OP_ADD:  {alu_carry, alu_res} = sum;
            OP_SUB:  {alu_carry, alu_res} = diff;
            OP_MUL: begin
                alu_res   = md_prod;
                alu_carry = md_hi_nz;
            end
            OP_DIV: begin
                if (b_q == '0) begin
                    alu_res = '1;
                    alu_dbz = 1'b1;
                end else begin
                    alu_res = md_quot;
                end
            end
            OP_SHL1: begin
                alu_res   = {a_q[WIDTH-2:0], 1'b0};
                alu_carry = a_q[WIDTH-1];
            end
            OP_SHR1: begin
                alu_res   = {1'b0, a_q[WIDTH-1:1]};
                alu_carry = a_q[0];
            end
            OP_ROL1: begin
                alu_res   = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
                alu_carry = a_q[WIDTH-1];
            end
            OP_ROR1: begin
                alu_res   = {a_q[0], a_q[WIDTH-1:1]};
                alu_carry = a_q[0];
            end
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_NOR:  alu_res = ~(a_q | b_q);
            OP_NAND: alu_res = ~(a_q & b_q);
            OP_XNOR: alu_res = ~(a_q ^ b_q);
            OP_GT:   alu_res = {{(WIDTH-1){1'b0}}, (a_q > b_q)};
            OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (a_q == b_q)};
            default: alu_res = '0;
        endcase
    end

    // First DONE cycle loads the output registers; they then hold until the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            result      <= '0;
            carry       <= 1'b0;
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
        end else if ((state == DONE) && !out_valid) begin
            out_valid   <= 1'b1;
            result      <= alu_res;
            carry       <= alu_carry;
            zero        <= (alu_res == '0);
            div_by_zero <= alu_dbz;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=8 with a scoreboard of expected results and latencies.
`timescale 1ns/1ps
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   op = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
    logic         div_by_zero;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .op          (op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .carry       (carry),
        .zero        (zero),
        .div_by_zero (div_by_zero)
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         d;
        logic [7:0]   lat;
    } exp_t;

    exp_t q[$];
    exp_t last_exp;
    int   n_asserts = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        exp_t        e;
        logic [8:0]  s;
        logic [15:0] p;
        e   = '0;
        e.lat = 8'd1;
        case (o)
            4'h0: begin s = {1'b0, x} + {1'b0, y}; e.res = s[7:0]; e.c = s[8]; end
            4'h1: begin e.res = x - y; e.c = (x < y); end
            4'h2: begin p = {8'h00, x} * {8'h00, y}; e.res = p[7:0]; e.c = (p[15:8] != 0); e.lat = 8'd9; end
            4'h3: begin
                if (y == 0) begin e.res = 8'hFF; e.d = 1'b1; end
                else begin e.res = x / y; e.lat = 8'd9; end
            end
            4'h4: begin e.res = x << 1; e.c = x[7]; end
            4'h5: begin e.res = x >> 1; e.c = x[0]; end
            4'h6: begin e.res = {x[6:0], x[7]}; e.c = x[7]; end
            4'h7: begin e.res = {x[0], x[7:1]}; e.c = x[0]; end
            4'h8: e.res = x & y;
            4'h9: e.res = x | y;
            4'hA: e.res = x ^ y;
            4'hB: e.res = ~(x | y);
            4'hC: e.res = ~(x & y);
            4'hD: e.res = ~(x ^ y);
            4'hE: e.res = (x > y) ? 8'd1 : 8'd0;
            default: e.res = (x == y) ? 8'd1 : 8'd0;
        endcase
        e.z = (e.res == 0);
        return e;
    endfunction

    // Called #1 after an edge; returns #1 after the accepting edge.
    task automatic send(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        logic got;
        got      = 1'b0;
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            got = in_ready;
            @(posedge clk);
            #1;
        end
        check("accept", got, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_result();
        int   cyc;
        exp_t e;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!out_valid && cyc < 40);
        check("out_valid", out_valid, 1);
        check("sb_nonempty", (q.size() > 0), 1);
        if (q.size() > 0) begin
            e = q.pop_front();
            last_exp = e;
            check("latency", cyc, e.lat);
            check("result", result, e.res);
            check("carry", carry, e.c);
            check("zero", zero, e.z);
            check("div_by_zero", div_by_zero, e.d);
        end
    endtask

    task automatic do_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        q.push_back(model(o, x, y));
        send(o, x, y);
        wait_result();
        @(posedge clk);
        #1;
    endtask

    logic [19:0] tbl [23] = '{
        20'h0_0A_02, 20'h0_F6_0A, 20'h1_02_0A, 20'h2_10_20, 20'h2_0A_02,
        20'h3_F6_0A, 20'h3_55_00, 20'h4_81_00, 20'h5_81_00, 20'h7_01_00,
        20'h8_C3_5A, 20'h9_C3_5A, 20'hA_C3_5A, 20'hB_C3_5A, 20'hC_C3_5A,
        20'hD_C3_5A, 20'hE_05_04, 20'hE_04_05, 20'hF_33_33, 20'hF_33_34,
        20'h2_FF_FF, 20'h3_07_09, 20'h1_0A_0A
    };

    initial begin
        logic [19:0] ent;
        int          pulses;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_carry", carry, 0);
        check("rst_zero", zero, 0);
        check("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        for (int i = 0; i < 23; i++) begin
            ent = tbl[i];
            do_op(ent[19:16], ent[15:8], ent[7:0]);
        end

        // Backpressure with a second bundle waiting on in_valid.
        out_ready = 1'b0;
        q.push_back(model(OP_ADD, 8'h33, 8'h44));
        send(OP_ADD, 8'h33, 8'h44);
        wait_result();
        op       = OP_XOR;
        a        = 8'h0F;
        b        = 8'hF0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_result", result, last_exp.res);
            check("bp_flags", {carry, zero, div_by_zero}, {last_exp.c, last_exp.z, last_exp.d});
        end
        out_ready = 1'b1;
        q.push_back(model(OP_XOR, 8'h0F, 8'hF0));
        @(posedge clk);
        #1;
        check("hs_out_valid", out_valid, 0);
        check("hs_not_taken", in_ready, 1);
        @(posedge clk);
        #1;
        check("next_accepted", in_ready, 0);
        in_valid = 1'b0;
        wait_result();
        @(posedge clk);
        #1;

        // Reset during a divide.
        send(OP_DIV, 8'hF6, 8'h0A);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("abort_busy", out_valid, 0);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_result", result, 0);
        check("abort_flags", {carry, zero, div_by_zero}, 3'b000);
        check("abort_in_ready", in_ready, 1);
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) rst_n = 1'b1;
            if (out_valid) pulses++;
        end
        check("abort_no_pulse", pulses, 0);
        do_op(OP_ROL1, 8'h81, 8'h00);
        check("sb_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
